// File: rtl/mux_bus_arbiter_pkg.sv
// mux_bus_arbiter_pkg: shared state encoding, channel ids and owner-state helper
//   state_e : ST_IDLE / ST_OWN0 / ST_OWN1 arbiter states
//   CH0/CH1 : requester channel ids
package mux_bus_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    function automatic state_e own_st(input logic ch);
        return ch ? ST_OWN1 : ST_OWN0;
    endfunction
endpackage

// File: rtl/mux32_21.sv
// mux32_21: 2:1 word mux
//   I0, I1 : input words
//   S      : select (1 picks I1)
//   o      : selected word
module mux32_21
    import mux_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             S,
    output logic [WIDTH-1:0] o
);
    assign o = S ? I1 : I0;
endmodule

// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter: round-robin burst arbiter sharing one registered word path between two requesters
//   clk, rst             : clock, synchronous active-high reset
//   in0_valid/data/ready : requester 0 handshake (ready = word accepted this cycle)
//   in1_valid/data/ready : requester 1 handshake
//   out_valid/data/src   : registered output word and its source channel
//   out_ready            : downstream accepts out_data
//   grant                : one-hot owner {OWN1, OWN0}, 2'b00 when idle
//   ARB_FIXED_PRIO_EN    : when defined, every tie-break picks channel 0 instead of round-robin
module mux_bus_arbiter
    import mux_bus_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [1:0]       grant
);
    localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_e             state_q, state_d, rel_st;
    logic               last_q, last_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic               out_valid_q, out_src_q;
    logic [WIDTH-1:0]   out_data_q, mux_o;
    logic               sel, slot, xfer, own_valid, last_beat, pick;

    mux32_21 #(.WIDTH(WIDTH)) u_mux (
        .I0 (in0_data),
        .I1 (in1_data),
        .S  (sel),
        .o  (mux_o)
    );

    assign sel       = state_q == ST_OWN1;
    assign slot      = !out_valid_q || out_ready;
    assign in0_ready = (state_q == ST_OWN0) && in0_valid && slot;
    assign in1_ready = (state_q == ST_OWN1) && in1_valid && slot;
    assign xfer      = in0_ready || in1_ready;
    assign own_valid = sel ? in1_valid : in0_valid;
    assign last_beat = bcnt_q == BCNT_W'(MAX_BURST - 1);

`ifdef ARB_FIXED_PRIO_EN
    assign pick   = in0_valid ? CH0 : CH1;
    assign rel_st = in0_valid ? ST_OWN0 : (in1_valid ? ST_OWN1 : ST_IDLE);
`else
    // On a tie the channel that did not own last wins; a release hands over only to the other side.
    logic oth_valid;
    assign oth_valid = sel ? in0_valid : in1_valid;
    assign pick      = (in0_valid && in1_valid) ? ~last_q : (in1_valid ? CH1 : CH0);
    assign rel_st    = oth_valid ? own_st(~sel) : ST_IDLE;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        if (state_q == ST_IDLE) begin
            if (in0_valid || in1_valid) state_d = own_st(pick);
        end else if (!own_valid || (xfer && last_beat)) begin
            // Owner went idle or used up its burst: unused burst count is discarded.
            state_d = rel_st;
            last_d  = sel;
            bcnt_d  = '0;
        end else if (xfer) begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= CH1;
            bcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= CH0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mux_o;
                out_src_q   <= sel;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign grant     = {state_q == ST_OWN1, state_q == ST_OWN0};
endmodule

// File: tb/tb_mux_bus_arbiter.sv
// tb_mux_bus_arbiter: directed self-checking bench for mux_bus_arbiter
module tb_mux_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in0_data = '0, in1_data = '0;
    logic        in0_ready, in1_ready, out_valid, out_src;
    logic [31:0] out_data;
    logic [1:0]  grant;
    logic        acc0, acc1;
    int          n_cmp = 0, n_bad = 0;

    mux_bus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        acc0 = in0_ready;
        acc1 = in1_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in0_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rst1_grant got %b want 00", grant); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst1_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst1_data got %h want 0", out_data); end
        tick();
        n_cmp++; if (acc0 !== 1'b0) begin n_bad++; $display("FAIL rst2_in0_ready got %b want 0", acc0); end
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rst2_grant got %b want 00", grant); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst2_valid got %b want 0", out_valid); end
        rst = 1'b0;
        tick();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rst_release_grant got %b want 01", grant); end
        in0_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] ed [9] = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'hA4, 32'hA5, 32'h0};
        int n = 0;
        do_reset();
        in0_valid = 1'b1;
        in0_data  = 32'hA0;
        for (int t = 0; t < 9; t++) begin
            tick();
            if (acc0) n++;
            in0_data = 32'hA0 + n;
            if (n == 6) in0_valid = 1'b0;
            n_cmp++; if (out_valid !== (ed[t] != 0)) begin n_bad++; $display("FAIL stream_valid[%0d] got %b want %b", t, out_valid, ed[t] != 0); end
            if (ed[t] != 0) begin
                n_cmp++; if (out_data !== ed[t]) begin n_bad++; $display("FAIL stream_data[%0d] got %h want %h", t, out_data, ed[t]); end
                n_cmp++; if (out_src !== 1'b0) begin n_bad++; $display("FAIL stream_src[%0d] got %b want 0", t, out_src); end
            end
        end
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL stream_end_grant got %b want 00", grant); end
    endtask

    task automatic test_alternate();
        logic [31:0] ed [12] = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h2000, 32'h2001,
                                 32'h2002, 32'h2003, 32'h1004, 32'h1005, 32'h1006, 32'h1007};
        int n0 = 0, n1 = 0;
        do_reset();
        in0_valid = 1'b1; in0_data = 32'h1000;
        in1_valid = 1'b1; in1_data = 32'h2000;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL alt_first_valid got %b want 0", out_valid); end
        for (int t = 0; t < 12; t++) begin
            tick();
            if (acc0) n0++;
            if (acc1) n1++;
            in0_data = 32'h1000 + n0;
            in1_data = 32'h2000 + n1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== ed[t] || out_src !== ed[t][13]) begin
                n_bad++; $display("FAIL alt_word[%0d] got v=%b d=%h s=%b want v=1 d=%h s=%b", t, out_valid, out_data, out_src, ed[t], ed[t][13]);
            end
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        in0_valid = 1'b1;
        in0_data  = 32'hDEADBEEF;
        tick();
        tick();
        n_cmp++; if (out_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stall_load got %h want deadbeef", out_data); end
        in0_data  = 32'h11111111;
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stall_hold[%0d] got v=%b d=%h want v=1 d=deadbeef", t, out_valid, out_data); end
            n_cmp++; if (acc0 !== 1'b0 || acc1 !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d] got %b%b want 00", t, acc1, acc0); end
            n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL stall_grant[%0d] got %b want 01", t, grant); end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (acc0 !== 1'b1 || out_data !== 32'h11111111) begin n_bad++; $display("FAIL stall_resume got r=%b d=%h want r=1 d=11111111", acc0, out_data); end
        tick();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL stall_word3_grant got %b want 01", grant); end
        tick();
        n_cmp++; if (grant !== 2'b00 || out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_word4 got g=%b v=%b want g=00 v=1", grant, out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_bubble got %b want 0", out_valid); end
        in0_valid = 1'b0;
    endtask

    task automatic test_drop();
        int n0 = 0;
        do_reset();
        in1_valid = 1'b1; in1_data = 32'h2000;
        tick();
        n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL drop_own1 got %b want 10", grant); end
        in0_valid = 1'b1; in0_data = 32'h1000;
        tick();
        in1_data = 32'h2001;
        n_cmp++; if (out_data !== 32'h2000 || out_src !== 1'b1) begin n_bad++; $display("FAIL drop_w0 got d=%h s=%b want d=2000 s=1", out_data, out_src); end
        tick();
        in1_valid = 1'b0;
        n_cmp++; if (out_data !== 32'h2001 || out_src !== 1'b1) begin n_bad++; $display("FAIL drop_w1 got d=%h s=%b want d=2001 s=1", out_data, out_src); end
        tick();
        n_cmp++; if (grant !== 2'b01 || out_valid !== 1'b0) begin n_bad++; $display("FAIL drop_release got g=%b v=%b want g=01 v=0", grant, out_valid); end
        in1_valid = 1'b1; in1_data = 32'h2002;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (acc0) n0++;
            in0_data = 32'h1000 + n0;
            n_cmp++; if (out_data !== 32'h1000 + t || out_src !== 1'b0) begin n_bad++; $display("FAIL drop_ch0[%0d] got d=%h s=%b want d=%h s=0", t, out_data, out_src, 32'h1000 + t); end
        end
        n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL drop_handback got %b want 10", grant); end
        tick();
        n_cmp++; if (out_data !== 32'h2002 || out_src !== 1'b1) begin n_bad++; $display("FAIL drop_ch1_again got d=%h s=%b want d=2002 s=1", out_data, out_src); end
        in0_valid = 1'b0; in1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        in0_valid = 1'b1; in0_data = 32'h55;
        tick();
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin n_bad++; $display("FAIL mid_pre got v=%b d=%h want v=1 d=55", out_valid, out_data); end
        rst = 1'b1;
        tick();
        n_cmp++; if (grant !== 2'b00 || out_valid !== 1'b0 || out_data !== 32'h0) begin n_bad++; $display("FAIL mid_rst got g=%b v=%b d=%h want g=00 v=0 d=0", grant, out_valid, out_data); end
        rst = 1'b0;
        tick();
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL mid_rearb got %b want 01", grant); end
        in0_valid = 1'b0;
    endtask

`ifdef ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        in0_valid = 1'b1; in0_data = 32'h1000;
        in1_valid = 1'b1; in1_data = 32'h2000;
        tick();
        for (int t = 0; t < 12; t++) begin
            tick();
            n_cmp++; if (acc1 !== 1'b0) begin n_bad++; $display("FAIL fixed_in1_ready[%0d] got %b want 0", t, acc1); end
            n_cmp++; if (out_valid !== 1'b1 || out_src !== 1'b0) begin n_bad++; $display("FAIL fixed_word[%0d] got v=%b s=%b want v=1 s=0", t, out_valid, out_src); end
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
`ifdef ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_alternate();
        test_drop();
`endif
        test_stall();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
